// File: rtl/pcm_audio_pkg.sv
// Shared constants and helpers for the PCM audio output path.
package pcm_audio_pkg;

  localparam int DEFAULT_DW = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Unsigned PCM code for silence.
  function automatic int midscale(input int dw);
    return 1 << (dw - 1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO; occupancy is tracked directly so full/empty come from level.
module sample_fifo
  import pcm_audio_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      level <= level + LVL_ONE;
      else if (do_pop && !do_push) level <= level - LVL_ONE;
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pcm_pwm_out.sv
// PCM-to-PWM speaker driver: samples queue in a FIFO, one is taken per divided-clock tick
// and becomes the PWM duty at the next period boundary.
module pcm_pwm_out
  import pcm_audio_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2,
  localparam int LW = clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_clk,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          pwm_out,
  output logic          underrun,
  output logic [LW-1:0] level
);

  localparam logic [DW-1:0] MID     = DW'(midscale(DW));
  localparam logic [DW-1:0] CNT_MAX = '1;
  localparam logic [DW-1:0] CNT_ONE = DW'(1);

  logic [SYNC_STAGES-1:0] tick_sync;
  logic                   tick_prev;
  logic                   strobe;
  logic                   push;
  logic                   pop;
  logic [DW-1:0]          head;
  logic                   full;
  logic                   empty;
  logic [DW-1:0]          cnt;
  logic [DW-1:0]          duty;
  logic [DW-1:0]          pend;
  logic                   pend_valid;

  // Synchroniser and rising-edge detect for the divided sample clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_sync <= '0;
      tick_prev <= 1'b0;
    end else begin
      tick_sync <= {tick_sync[SYNC_STAGES-2:0], tick_clk};
      tick_prev <= tick_sync[SYNC_STAGES-1];
    end
  end

  assign strobe  = tick_sync[SYNC_STAGES-1] & ~tick_prev;
  assign s_ready = ~full;
  assign push    = s_valid & s_ready;
  assign pop     = strobe & ~empty;

  sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // PWM counter, pending sample and duty; a pop in the wrap cycle wins pend_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      duty       <= MID;
      pend       <= MID;
      pend_valid <= 1'b0;
      pwm_out    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      cnt      <= cnt + CNT_ONE;
      pwm_out  <= (cnt < duty);
      underrun <= strobe & empty;
      if (cnt == CNT_MAX && pend_valid) begin
        duty       <= pend;
        pend_valid <= 1'b0;
      end
      if (pop) begin
        pend       <= head;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcm_pwm_out.sv
// Scoreboard bench for pcm_pwm_out: duty per PWM period and underrun timing are predicted when ticks are driven.
module tb_pcm_pwm_out;

  typedef struct {
    int win;
    int duty;
  } dexp_t;

  logic       clk;
  logic       reset;
  logic       tick_clk;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       pwm_out;
  logic       underrun;
  logic [2:0] level;

  int checks;
  int failures;
  int edges;
  int hi;
  int cur_duty;
  int exp_level;

  logic [7:0] fq[$];
  dexp_t      dq[$];
  int         uq[$];

  pcm_pwm_out #(
    .DW          (8),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_clk (tick_clk),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .pwm_out  (pwm_out),
    .underrun (underrun),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) edges <= 0;
    else        edges <= edges + 1;
  end

  // Output after edge n reflects cnt = n-1, so each 256-edge block is one whole PWM period.
  always @(negedge clk) begin
    dexp_t e;
    int p;
    if (!reset) begin
      hi = 0;
    end else begin
      hi = hi + (pwm_out ? 1 : 0);
      if (underrun) begin
        if (uq.size() == 0) chk("underrun_unexpected", edges, -1);
        else                chk("underrun_cycle", edges, uq.pop_front());
      end
      if (edges != 0 && (edges % 256) == 0) begin
        p = edges / 256 - 1;
        if (dq.size() > 0 && dq[0].win == p) begin
          e = dq.pop_front();
          cur_duty = e.duty;
          chk("duty_change", hi, e.duty);
        end else begin
          chk("duty_steady", hi, cur_duty);
        end
        hi = 0;
      end
    end
  end

  task automatic push(input logic [7:0] d);
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 1000 && !s_ready; i++) @(negedge clk);
    if (s_ready) begin
      fq.push_back(d);
      exp_level = exp_level + 1;
    end else begin
      chk("push_timeout", 0, 1);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    @(negedge clk);
    for (int i = 0; i < 300 && (edges % 256) != ph; i++) @(negedge clk);
  endtask

  // Called at a negedge: tick_clk is sampled high at edge k = edges+1, pop lands at edge k+2.
  task automatic tick(input bit aligned, input logic [7:0] d);
    int k;
    bit acc;
    dexp_t e;
    k = edges + 1;
    tick_clk = 1'b1;
    if (fq.size() > 0) begin
      e.win  = (k + 3 + 255) / 256;
      e.duty = int'(fq.pop_front());
      dq.push_back(e);
      exp_level = exp_level - 1;
    end else begin
      uq.push_back(k + 2);
    end
    acc = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (acc) begin
        s_valid = 1'b0;
        acc = 1'b0;
      end
      if (i == 4) tick_clk = 1'b0;
      if (aligned && i == 2) begin
        s_valid = 1'b1;
        s_data  = d;
      end
      if (s_valid && s_ready) begin
        acc = 1'b1;
        fq.push_back(s_data);
        exp_level = exp_level + 1;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    hi = 0;
    cur_duty = 128;
    exp_level = 0;
    reset = 1'b0;
    tick_clk = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(s_ready), 1);
    chk("rst_underrun", int'(underrun), 0);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(s_ready), 1);
    chk("post_rst_level", int'(level), 0);
    chk("first_pwm", int'(pwm_out), 1);

    push(8'h40);
    push(8'hC0);
    push(8'h00);
    push(8'hFF);
    chk("full_level", int'(level), 4);
    chk("full_ready", int'(s_ready), 0);
    s_valid = 1'b1;
    s_data  = 8'h20;
    repeat (5) @(negedge clk);
    chk("held_level", int'(level), 4);
    chk("held_ready", int'(s_ready), 0);

    wait_phase(50);
    tick(1'b0, 8'h00);
    s_valid = 1'b0;
    chk("refill_level", int'(level), exp_level);
    for (int t = 0; t < 4; t++) begin
      wait_phase(50);
      tick(1'b0, 8'h00);
      chk("drain_level", int'(level), exp_level);
    end

    wait_phase(50);
    tick(1'b0, 8'h00);
    chk("underrun_level", int'(level), 0);

    wait_phase(50);
    tick(1'b1, 8'h60);
    chk("aligned_level", int'(level), 1);
    wait_phase(50);
    tick(1'b0, 8'h00);
    chk("aligned_pop_level", int'(level), 0);

    wait_phase(20);
    push(8'hA0);
    push(8'h30);
    wait_phase(100);
    tick(1'b0, 8'h00);
    wait_phase(253);
    tick(1'b0, 8'h00);
    chk("wrap_level", int'(level), 0);

    for (int i = 0; i < 1200 && dq.size() > 0; i++) @(negedge clk);
    chk("duty_drain", dq.size(), 0);

    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("mid_level", int'(level), 3);
    for (int i = 0; i < 600 && !pwm_out; i++) @(negedge clk);
    chk("mid_pwm_high", int'(pwm_out), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_pwm", int'(pwm_out), 0);
    chk("async_level", int'(level), 0);
    chk("async_ready", int'(s_ready), 1);
    fq.delete();
    exp_level = 0;
    cur_duty = 128;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (3 * 256 + 10) @(negedge clk);
    chk("final_level", int'(level), 0);
    chk("underrun_pending", uq.size(), 0);
    chk("duty_pending", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcm_pwm_out.md
Name: pcm_pwm_out

Overview:
- Downstream consumer of the audio sample-rate divider: converts unsigned PCM samples into a PWM bitstream for the speaker (Altavoz) output pin.
- The divided clock (`clkout`) arrives as a plain data input `tick_clk`. It is synchronised and edge-detected into a one-cycle sample strobe; no logic runs on it as a clock.
- Samples enter through a valid/ready handshake into a small FIFO. One sample is popped per strobe and applied to the PWM duty at the next PWM period boundary.

Parameters:
- DW, 8, sample width and PWM counter width; PWM period = 2^DW clk cycles.
- DEPTH, 4, FIFO depth in samples; power of two, >= 2.
- SYNC_STAGES, 2, synchroniser flops on `tick_clk`; >= 2.

Ports:
- clk, in, 1, system clock; single clock domain.
- reset, in, 1, asynchronous active-low reset; asserts immediately, releases synchronously to clk.
- tick_clk, in, 1, divided sample-rate clock from the divider, treated as asynchronous data.
- s_data, in, DW, unsigned PCM sample; midscale 2^(DW-1) = silence.
- s_valid, in, 1, s_data valid.
- s_ready, out, 1, FIFO not full.
- pwm_out, out, 1, registered PWM output to the speaker.
- underrun, out, 1, one-cycle pulse: strobe occurred with FIFO empty.
- level, out, clog2(DEPTH)+1, FIFO occupancy.

Behaviour:
- Reset values:
  - FIFO empty; level = 0; s_ready = 1.
  - pwm_out = 0; underrun = 0; PWM counter cnt = 0.
  - duty = pend = 2^(DW-1); pend_valid = 0.
  - Synchroniser and edge-detect flops = 0.
- Strobe generation:
  - tick_clk passes through SYNC_STAGES flops; a further flop holds the previous synchronised value.
  - strobe = sync_last & ~prev.
  - If tick_clk is sampled high at edge k, strobe is high during the cycle after edge k+SYNC_STAGES-1. Its action takes effect at edge k+SYNC_STAGES.
  - Exactly one strobe per tick_clk rising edge; falling edges are ignored.
- Push: occurs when s_valid & s_ready. s_ready = (level != DEPTH), combinational from registered state.
- Pop:
  - On strobe with level > 0: the head goes to pend, pend_valid is set, and level decrements.
  - On strobe with level == 0: underrun pulses for 1 cycle; pend and pend_valid are unchanged.
- Simultaneous push and pop: level unchanged and data order preserved.
- Push into an empty FIFO on the same cycle as a strobe: no bypass. The push is accepted, the pop does not occur, underrun pulses, and level becomes 1.
- FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from level.
- PWM:
  - cnt increments every clk and wraps from 2^DW-1 to 0.
  - pwm_out <= (cnt < duty), registered one cycle.
  - duty = 0 gives a constant 0. Duty 2^DW-1 gives high for 2^DW-1 of 2^DW cycles.
- Duty update:
  - In the cycle where cnt == 2^DW-1 and pend_valid: duty <= pend and pend_valid <= 0. The new duty governs from cnt = 0, so no mid-period glitch.
  - If a strobe and the wrap occur in the same cycle, the wrap loads the old pend and the strobe writes the new pend. The new sample applies at the next wrap.
  - A second strobe before a wrap overwrites pend; the earlier sample is dropped and no flag is raised.
  - On underrun, duty holds its last value.
- Reset mid-operation: all state returns to reset values immediately, the FIFO contents are discarded, and pwm_out is forced to 0.

Decomposition:
- Shared package `pcm_audio_pkg` holds:
  - default sample width (8);
  - the MIDSCALE function/constant 2^(DW-1);
  - clog2 helper.
- One sub-module, `sample_fifo`: parameterised DW/DEPTH synchronous FIFO with push, pop, head data, level, full and empty, using the same async active-low reset.
- The synchroniser, edge detect, pend register and PWM stay in the top level.

Test Plan:
- Reset release, no stimulus: s_ready = 1, level = 0, pwm_out = 0. With DW = 8, pwm_out is high 128 of every 256 cycles from cycle 1.
- Push 0x40, 0xC0, 0x00, 0xFF back-to-back: level = 4, s_ready = 0. A 5th s_valid is held off with no data loss.
  - Then 4 tick_clk rising edges, each >= 256 cycles apart: duty sequence 64 → 192 → 0 → 255 high cycles per period.
  - Each duty change lands exactly at a cnt wrap.
- tick_clk rising edge with FIFO empty: underrun high for exactly 1 cycle, SYNC_STAGES+1 clocks after the edge; duty unchanged.
- Push aligned to the same cycle as a strobe on an empty FIFO: underrun pulses, level = 1. The next strobe pops the sample.
- Strobe coinciding with the cnt == 255 wrap cycle: the previously pending sample applies now and the new sample applies one period (256 cycles) later.
- Assert reset mid-stream with level = 3 and pwm_out = 1: pwm_out = 0 and level = 0 asynchronously. After release, duty = 128.
